alu_arbiter: RTL and testbench

Shares the single registered 8-bit ALU among NUM_REQ independent requesters. Each requester issues one operation with a valid/ready handshake and gets back result, zero and overflow flags on its own response handshake. Arbitration is round-robin. The block sequences the ALU's one-cycle registered latency and captures its outputs in exactly the right cycle. It sits between the requester ports (sequencers, DMA-side compute clients) and the ALU instance.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcodes, arbiter FSM state encoding and opcode legality check
//                shared by the ALU arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] ADD     = 4'd0;
   localparam logic [3:0] SUB     = 4'd1;
   localparam logic [3:0] AND     = 4'd2;
   localparam logic [3:0] OR      = 4'd3;
   localparam logic [3:0] XOR     = 4'd4;
   localparam logic [3:0] SHL     = 4'd5;
   localparam logic [3:0] SHR     = 4'd6;
   localparam logic [3:0] CMP     = 4'd7;
   localparam logic [3:0] OP_IDLE = 4'hF;

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_issue   = 2'd1;
   localparam logic [1:0] c_st_capture = 2'd2;
   localparam logic [1:0] c_st_respond = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = c_st_idle,
      ISSUE   = c_st_issue,
      CAPTURE = c_st_capture,
      RESPOND = c_st_respond
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= CMP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick; the first requester above
//                last_grant (with wrap-around) wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] w_idx;

   // Walk from the farthest candidate to the nearest so the nearest one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_idx     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
         if (req[w_idx]) begin
            grant        = '0;
            grant[w_idx] = 1'b1;
            grant_idx    = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one registered 8-bit ALU among
//                NUM_REQ requesters, one operation in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   input  logic [NUM_REQ*4-1:0] req_op,
   output logic [NUM_REQ-1:0]   rsp_valid,
   input  logic [NUM_REQ-1:0]   rsp_ready,
   output logic [7:0]           rsp_result,
   output logic                 rsp_zero,
   output logic                 rsp_ovf,
   output logic                 rsp_err,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [3:0]           alu_opcode,
   input  logic [7:0]           alu_result,
   input  logic                 alu_zero_flag,
   input  logic                 alu_overflow_flag,
   output logic                 busy,
   output logic [CNT_W-1:0]     ops_done
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t             r_state;
   logic [IDX_W-1:0]   r_last_grant;
   logic [IDX_W-1:0]   r_grant_idx;
   logic [7:0]         r_alu_a;
   logic [7:0]         r_alu_b;
   logic [3:0]         r_alu_opcode;
   logic [7:0]         r_rsp_result;
   logic               r_rsp_zero;
   logic               r_rsp_ovf;
   logic               r_rsp_err;
   logic [CNT_W-1:0]   r_ops_done;

   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_grant_idx;
   logic [7:0]         w_sel_a;
   logic [7:0]         w_sel_b;
   logic [3:0]         w_sel_op;
   logic               w_accept;
   logic               w_rsp_hs;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req        (req_valid),
      .last_grant (r_last_grant),
      .grant      (w_grant),
      .grant_idx  (w_grant_idx)
   );

   assign w_accept = (r_state == IDLE) && (|req_valid);
   assign w_rsp_hs = (r_state == RESPOND) && rsp_ready[r_grant_idx];
   assign w_sel_a  = req_a[{w_grant_idx, 3'b000} +: 8];
   assign w_sel_b  = req_b[{w_grant_idx, 3'b000} +: 8];
   assign w_sel_op = req_op[{w_grant_idx, 2'b00} +: 4];

   // Ready depends only on the request vector and the IDLE state, never on rsp_ready.
   assign req_ready  = (r_state == IDLE) ? w_grant : '0;
   assign rsp_valid  = (r_state == RESPOND) ? (NUM_REQ'(1) << r_grant_idx) : '0;
   assign rsp_result = r_rsp_result;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_ovf    = r_rsp_ovf;
   assign rsp_err    = r_rsp_err;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_opcode;
   assign busy       = (r_state != IDLE);
   assign ops_done   = r_ops_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_grant_idx  <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_opcode <= OP_IDLE;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
         r_rsp_ovf    <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_ops_done   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_grant_idx  <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  if (is_legal_op(w_sel_op)) begin
                     r_alu_a      <= w_sel_a;
                     r_alu_b      <= w_sel_b;
                     r_alu_opcode <= w_sel_op;
                     r_state      <= ISSUE;
                  end else begin
                     // Illegal opcodes bypass the ALU and answer immediately.
                     r_rsp_result <= '0;
                     r_rsp_zero   <= 1'b0;
                     r_rsp_ovf    <= 1'b0;
                     r_rsp_err    <= 1'b1;
                     r_state      <= RESPOND;
                  end
               end
            end
            ISSUE: begin
               r_alu_opcode <= OP_IDLE;
               r_state      <= CAPTURE;
            end
            CAPTURE: begin
               r_rsp_result <= alu_result;
               r_rsp_zero   <= alu_zero_flag;
               r_rsp_ovf    <= alu_overflow_flag;
               r_rsp_err    <= 1'b0;
               r_state      <= RESPOND;
            end
            RESPOND: begin
               if (w_rsp_hs) begin
                  r_ops_done <= r_ops_done + CNT_W'(1);
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a registered ALU
//                model and a transaction-level reference of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 16;

   typedef struct packed {
      logic [7:0] result;
      logic       zero;
      logic       ovf;
      logic       err;
   } rsp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NUM_REQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NUM_REQ*8-1:0] req_a, req_b;
   logic [NUM_REQ*4-1:0] req_op;
   logic [7:0]           rsp_result, alu_a, alu_b, alu_result;
   logic                 rsp_zero, rsp_ovf, rsp_err, alu_zero_flag, alu_overflow_flag, busy;
   logic [3:0]           alu_opcode;
   logic [CNT_W-1:0]     ops_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: one transaction in flight, identified by its accept cycle.
   bit                 m_busy;
   int                 m_last, m_g, m_acc, m_lat;
   logic [7:0]         m_a, m_b;
   logic [3:0]         m_op;
   rsp_t               m_rsp;
   logic [CNT_W-1:0]   m_ops;
   logic [NUM_REQ-1:0] m_acc_mask;

   always #5 clk = ~clk;

   alu_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_zero_flag(alu_zero_flag), .alu_overflow_flag(alu_overflow_flag),
      .busy(busy), .ops_done(ops_done)
   );

   // ALU behaviour: returns {result, zero, overflow}; idle opcode yields all zero.
   function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      logic [8:0] wide;
      logic [7:0] res;
      logic       ovf;
      wide = '0;
      res  = '0;
      ovf  = 1'b0;
      case (op)
         ADD: begin wide = {1'b0, a} + {1'b0, b}; res = wide[7:0]; ovf = wide[8]; end
         SUB: begin res = a - b; ovf = (a < b); end
         AND: res = a & b;
         OR:  res = a | b;
         XOR: res = a ^ b;
         SHL: res = a << b[2:0];
         SHR: res = a >> b[2:0];
         CMP: res = (a > b) ? 8'd1 : 8'd0;
         default: return 10'd0;
      endcase
      return {res, (res == 8'd0), ovf};
   endfunction

   function automatic rsp_t expect_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      if (op >= 4'd8) return {8'd0, 1'b0, 1'b0, 1'b1};
      return {alu_fn(a, b, op), 1'b0};
   endfunction

   function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
      for (int k = 1; k <= NUM_REQ; k++)
         if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) {alu_result, alu_zero_flag, alu_overflow_flag} <= 10'd0;
      else        {alu_result, alu_zero_flag, alu_overflow_flag} <= alu_fn(alu_a, alu_b, alu_opcode);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   // Compare every DUT output with the reference, then account for the coming edge.
   task automatic sample();
      logic [NUM_REQ-1:0] x_ready, x_rsp;
      logic [3:0]         x_opc;
      int                 p, age;
      @(negedge clk);
      cyc++;
      x_ready = '0;
      p = -1;
      if (!m_busy) begin
         p = rr_pick(req_valid, m_last);
         if (p >= 0) x_ready[p] = 1'b1;
      end
      age   = cyc - m_acc;
      x_rsp = '0;
      if (m_busy && age >= m_lat) x_rsp[m_g] = 1'b1;
      x_opc = (m_busy && age == 1 && m_lat == 3) ? m_op : OP_IDLE;
      check("req_ready", 32'(req_ready), 32'(x_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(x_rsp));
      check("busy", 32'(busy), 32'(m_busy));
      check("ops_done", 32'(ops_done), 32'(m_ops));
      check("alu_opcode", 32'(alu_opcode), 32'(x_opc));
      if (x_opc != OP_IDLE) check("alu_operands", 32'({alu_a, alu_b}), 32'({m_a, m_b}));
      if (x_rsp != '0) check("rsp_fields", 32'({rsp_result, rsp_zero, rsp_ovf, rsp_err}), 32'(m_rsp));
      m_acc_mask = x_ready;
      if (x_rsp != '0 && rsp_ready[m_g]) begin
         m_busy = 1'b0;
         m_ops  = m_ops + 1'b1;
      end else if (p >= 0) begin
         m_busy = 1'b1;
         m_g    = p;
         m_last = p;
         m_acc  = cyc;
         m_a    = req_a[8*p +: 8];
         m_b    = req_b[8*p +: 8];
         m_op   = req_op[4*p +: 4];
         m_lat  = (m_op < 4'd8) ? 3 : 1;
         m_rsp  = expect_rsp(m_a, m_b, m_op);
      end
   endtask

   task automatic apply_reset(input int ncyc);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      repeat (ncyc) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_busy = 1'b0;
      m_last = NUM_REQ - 1;
      m_ops  = '0;
      m_acc  = 0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_fields", 32'({rsp_result, rsp_zero, rsp_ovf, rsp_err}), 32'd0);
      check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
      check("rst_alu_opcode", 32'(alu_opcode), 32'(OP_IDLE));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ops_done", 32'(ops_done), 32'd0);
      advance();
   endtask

   task automatic single(input int r, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [NUM_REQ-1:0] others, input int hold, input rsp_t xr, input int xlat);
      int               acc_c, lat;
      bit               got;
      logic [CNT_W-1:0] ops_before;
      logic [10:0]      seen;
      req_a[8*r +: 8]  = a;
      req_b[8*r +: 8]  = b;
      req_op[4*r +: 4] = op;
      req_valid        = '0;
      req_valid[r]     = 1'b1;
      rsp_ready        = '0;
      ops_before       = ops_done;
      got = 0; acc_c = 0; lat = 0; seen = '0;
      for (int n = 0; n < 8 && !got; n++) begin
         sample();
         if (req_ready[r]) begin got = 1; acc_c = cyc; end
         advance();
      end
      check("accept_seen", 32'(got), 32'd1);
      req_valid    = others;
      req_valid[r] = 1'b0;
      rsp_ready    = '1;
      rsp_ready[r] = 1'b0;
      got = 0;
      for (int n = 0; n < 12 && !got; n++) begin
         sample();
         if (rsp_valid[r]) begin got = 1; lat = cyc - acc_c; seen = {rsp_result, rsp_zero, rsp_ovf, rsp_err}; end
         advance();
      end
      check("rsp_seen", 32'(got), 32'd1);
      check("latency", 32'(lat), 32'(xlat));
      check("rsp_expected", 32'(seen), 32'(xr));
      for (int n = 0; n < hold; n++) begin
         sample();
         check("rsp_hold", 32'({rsp_result, rsp_zero, rsp_ovf, rsp_err}), 32'(xr));
         advance();
      end
      rsp_ready[r] = 1'b1;
      sample();
      advance();
      req_valid = '0;
      rsp_ready = '0;
      sample();
      check("ops_done_step", 32'(ops_done), 32'(ops_before + 1'b1));
      advance();
   endtask

   task automatic rand_req(input int i);
      req_a[8*i +: 8]  = 8'($urandom);
      req_b[8*i +: 8]  = 8'($urandom);
      req_op[4*i +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
   endtask

   task automatic random_run(input int ncyc, input bit all_valid, input bit rsp_all);
      int grants[$];
      for (int i = 0; i < NUM_REQ; i++) begin
         rand_req(i);
         req_valid[i] = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
      end
      rsp_ready = rsp_all ? '1 : NUM_REQ'($urandom);
      for (int c = 0; c < ncyc; c++) begin
         sample();
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grants.push_back(i);
         advance();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (m_acc_mask[i] || !req_valid[i]) begin
               rand_req(i);
               req_valid[i] = all_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
            end else if (!all_valid && $urandom_range(0, 7) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = rsp_all ? '1 : NUM_REQ'($urandom);
      end
      if (all_valid) begin
         check("grant_count", 32'(grants.size() >= 8), 32'd1);
         for (int k = 0; k < grants.size() && k < 8; k++)
            check("grant_order", 32'(grants[k]), 32'(k % NUM_REQ));
      end
      req_valid = '0;
      rsp_ready = '1;
      for (int c = 0; c < 6; c++) begin sample(); advance(); end
      rsp_ready = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit expired before the bench completed");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      req_valid = '0; rsp_ready = '0;
      req_a = '0; req_b = '0; req_op = '0;
      m_acc_mask = '0; m_g = 0; m_lat = 3; m_a = '0; m_b = '0; m_op = OP_IDLE; m_rsp = '0;

      apply_reset(2);

      single(0, 8'd200, 8'd100, ADD, 4'b0000, 0, {8'd44, 1'b0, 1'b1, 1'b0}, 3);
      check("ops_done_first", 32'(ops_done), 32'd1);

      single(2, 8'd5, 8'd5, SUB, 4'b0000, 0, {8'd0, 1'b1, 1'b0, 1'b0}, 3);
      single(2, 8'd3, 8'd5, SUB, 4'b0000, 0, {8'd254, 1'b0, 1'b1, 1'b0}, 3);

      single(1, 8'd77, 8'd12, 4'hA, 4'b0000, 0, {8'd0, 1'b0, 1'b0, 1'b1}, 1);

      single(3, 8'd9, 8'd4, CMP, 4'b0111, 10, {8'd1, 1'b0, 1'b0, 1'b0}, 3);

      random_run(80, 1'b1, 1'b1);
      random_run(300, 1'b0, 1'b0);

      // Reset landing while the ALU result is being captured.
      req_a[15:8] = 8'd50; req_b[15:8] = 8'd60; req_op[7:4] = ADD;
      req_valid = 4'b0010;
      got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
         sample();
         if (req_ready[1]) got = 1;
         advance();
      end
      check("reset_test_accept", 32'(got), 32'd1);
      req_valid = '0;
      sample();
      advance();
      sample();
      apply_reset(1);
      for (int c = 0; c < 6; c++) begin sample(); advance(); end

      random_run(40, 1'b1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
